// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file and its clear engine.
package regfile_mp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

    // Address width for a given depth; a depth of 1 still needs one address bit.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_mp_clr_fsm.sv
// Bulk-clear sequencer: walks a pointer across every register, one per cycle,
// and pulses clr_done on the first idle cycle after the sweep.
//
// state    | meaning
// ST_IDLE  | waiting for clr_req; register file accepts writes/reserves
// ST_CLEAR | clearing entry clr_ptr this cycle; busy asserted
module regfile_mp_clr_fsm
    import regfile_mp_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = addr_w(DEF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic [AW-1:0] clr_ptr,
    output logic          clr_we
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Last entry is cleared this cycle; park the pointer instead of wrapping.
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_ptr  = ptr_q;
    assign clr_done = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with pending-bit scoreboard and bulk clear.
// Optional macro REGFILE_MP_BYPASS_EN forwards an accepted write to matching read ports.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter int  NUM_RD   = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;

    logic [AW-1:0] clr_ptr;
    logic          clr_we;
    logic          wr_ok, rsv_ok;

    regfile_mp_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .clr_ptr  (clr_ptr),
        .clr_we   (clr_we)
    );

    assign wr_ok  = wr_en  && !busy && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok = rsv_en && !busy && !((ZERO_REG != 0) && (rsv_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    // Clear engine owns the write path while busy; reserve is applied after the
    // write so a same-address reserve leaves the entry pending.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (clr_we) begin
            mem_d[clr_ptr]  = '0;
            pend_d[clr_ptr] = 1'b0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_addr]  = wr_data;
                pend_d[wr_addr] = 1'b0;
            end
            if (rsv_ok) begin
                pend_d[rsv_addr] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              pend;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data = mem_q[addr];
            pend = pend_q[addr];
`ifdef REGFILE_MP_BYPASS_EN
            if (wr_ok && (wr_addr == addr)) begin
                data = wr_data;
                pend = 1'b0;
            end
            if (rsv_ok && (rsv_addr == addr)) begin
                pend = 1'b1;
            end
`endif
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
                pend = 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data;
        assign rd_pend[i]                  = pend;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters: 16x16, 2 read ports, zero register).
module tb_regfile_mp;

    localparam int DW = 16;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int NRD = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DW-1:0]     rd_data;
    logic [NRD-1:0]        rd_pend;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DW-1:0]         wr_data;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic                  clr_req;
    logic                  busy;
    logic                  clr_done;

    regfile_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_pend  (rd_pend),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: register contents, pending flags, and the clear sweep
    // tracked as "how many entries have been wiped so far".
    logic [DW-1:0] m_r [DEPTH];
    bit            m_p [DEPTH];
    bit            m_busy;
    int            m_k;
    bit            m_done;

    task automatic model_edge();
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                m_r[a] = '0;
                m_p[a] = 1'b0;
            end
            m_busy = 1'b0;
            m_k    = 0;
            m_done = 1'b0;
        end else if (m_busy) begin
            m_r[m_k] = '0;
            m_p[m_k] = 1'b0;
            m_k++;
            m_done = 1'b0;
            if (m_k == DEPTH) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (wr_en && wr_addr != 0) begin
                m_r[wr_addr] = wr_data;
                m_p[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_p[rsv_addr] = 1'b1;
            if (clr_req) begin
                m_busy = 1'b1;
                m_k    = 0;
            end
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int a);
        logic [DW-1:0] v;
        v = (a == 0) ? '0 : m_r[a];
`ifdef REGFILE_MP_BYPASS_EN
        if (!m_busy && wr_en && int'(wr_addr) == a && a != 0) v = wr_data;
`endif
        return v;
    endfunction

    function automatic logic exp_pend(input int a);
        logic p;
        p = (a == 0) ? 1'b0 : m_p[a];
`ifdef REGFILE_MP_BYPASS_EN
        if (!m_busy && a != 0) begin
            if (wr_en  && int'(wr_addr)  == a) p = 1'b0;
            if (rsv_en && int'(rsv_addr) == a) p = 1'b1;
        end
`endif
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        #1;
        for (int i = 0; i < NRD; i++) begin
            int a;
            a = int'(rd_addr[i*AW +: AW]);
            chk({tag, "/rd_data"}, 32'(rd_data[i*DW +: DW]), 32'(exp_data(a)));
            chk({tag, "/rd_pend"}, 32'(rd_pend[i]), 32'(exp_pend(a)));
        end
        chk({tag, "/busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "/clr_done"}, 32'(clr_done), 32'(m_done));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; rsv_en = 0; clr_req = 0;
        wr_addr = '0; wr_data = '0; rsv_addr = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic do_wr(input int a, input logic [DW-1:0] d);
        wr_en = 1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic sweep_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(a, a);
            #1;
            chk(tag, 32'(rd_data[DW-1:0]), 32'h0);
            chk(tag, 32'(rd_pend), 32'h0);
        end
    endtask

    initial begin
        int bc, dc;
        rst_n = 0;
        idle_inputs();
        set_rd(0, 1);

        // Reset
        tick(); tick();
        rst_n = 1;
        chk_all("reset");
        chk("reset_data", 32'(rd_data), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Write / read; register 0 is hard-wired to zero
        do_wr(0, 16'hABCD);
        do_wr(1, 16'hBFF0);
        set_rd(0, 1);
        chk_all("wr_rd");
        chk("wr_rd_p0", 32'(rd_data[15:0]), 32'h0000);
        chk("wr_rd_p1", 32'(rd_data[31:16]), 32'hBFF0);

        // Scoreboard
        rsv_en = 1; rsv_addr = 5;
        tick();
        rsv_en = 0;
        set_rd(5, 1);
        chk_all("rsv");
        chk("rsv_pend", 32'(rd_pend[0]), 32'h1);
        do_wr(5, 16'h1234);
        chk_all("wr_after_rsv");
        chk("wr_after_rsv_pend", 32'(rd_pend[0]), 32'h0);
        wr_en = 1; wr_addr = 6; wr_data = 16'h5555; rsv_en = 1; rsv_addr = 6;
        tick();
        idle_inputs();
        set_rd(6, 6);
        chk_all("rsv_wins");
        chk("rsv_wins_data", 32'(rd_data[15:0]), 32'h5555);
        chk("rsv_wins_pend", 32'(rd_pend), 32'h3);

        // Bulk clear with a dropped write mid-sweep
        for (int a = 1; a < DEPTH; a++) do_wr(a, 16'h00FF);
        set_rd(9, 15);
        chk_all("preload");
        chk("preload_r9", 32'(rd_data[15:0]), 32'h00FF);
        clr_req = 1;
        tick();
        clr_req = 0;
        bc = 0; dc = 0;
        set_rd(3, 15);
        for (int c = 0; c < 25; c++) begin
            chk_all("clear");
            if (busy) bc++;
            if (clr_done) dc++;
            if (c == 3) begin
                wr_en = 1; wr_addr = 3; wr_data = 16'hAAAA;
            end else begin
                wr_en = 0;
            end
            tick();
        end
        chk("clear_busy_cycles", 32'(bc), 32'd16);
        chk("clear_done_pulses", 32'(dc), 32'd1);
        set_rd(3, 3);
        #1;
        chk("clear_dropped_wr", 32'(rd_data[15:0]), 32'h0000);
        sweep_zero("clear_sweep");

        // Reset in the middle of a clear
        for (int a = 1; a < DEPTH; a++) do_wr(a, DW'(a * 16'h0111));
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int c = 1; c < 7; c++) tick();
        chk("midclr_busy_before", 32'(busy), 32'h1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("midclr_busy", 32'(busy), 32'h0);
        sweep_zero("midclr_sweep");
        dc = 0;
        for (int c = 0; c < 20; c++) begin
            set_rd(12, 15);
            chk_all("midclr_after");
            if (clr_done) dc++;
            tick();
        end
        chk("midclr_no_done", 32'(dc), 32'd0);

        // Write-to-read bypass (or lack of it)
        do_wr(2, 16'h1111);
        set_rd(2, 4);
        wr_en = 1; wr_addr = 2; wr_data = 16'hBEEF;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        chk("bypass_same_cycle", 32'(rd_data[15:0]), 32'hBEEF);
`else
        chk("bypass_same_cycle", 32'(rd_data[15:0]), 32'h1111);
`endif
        chk_all("bypass_model");
        tick();
        wr_en = 0;
        chk("bypass_next_cycle", 32'(rd_data[15:0]), 32'hBEEF);

        // clr_req held high across done restarts a clear
        clr_req = 1;
        for (int c = 0; c < 40; c++) begin
            chk_all("clr_level");
            tick();
        end
        clr_req = 0;
        for (int c = 0; c < 20; c++) begin
            chk_all("clr_level_drain");
            tick();
        end

        // Randomised traffic against the model
        for (int c = 0; c < 600; c++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom);
            wr_data  = DW'($urandom);
            rsv_en   = 1'($urandom_range(0, 1));
            rsv_addr = (($urandom_range(0, 3) == 0)) ? wr_addr : AW'($urandom);
            clr_req  = ($urandom_range(0, 39) == 0);
            rd_addr  = (($urandom_range(0, 3) == 0)) ? {wr_addr, rsv_addr} : NRD*AW'($urandom);
            chk_all("random");
            tick();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
